// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg
// Brief    : ID/EX pipeline register with 2-entry skid, flush and bubble count
// Revision : 1.0
// ============================================================================
module id_ex_stage_reg #(
  parameter int CTRL_W    = 10,
  parameter int DATA_W    = 26,
  parameter int GATE_CTRL = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  bubble_cnt,
  input  logic              bubble_clr
);

  logic              r_out_valid;
  logic              r_skid_valid;
  logic              r_in_ready;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_accept;
  logic w_main_free;

  assign w_accept    = in_valid & r_in_ready;
  assign w_main_free = ~r_out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_main_ctrl  <= '0;
      r_main_data  <= '0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
    end else if (flush) begin
      // out_data deliberately keeps its value; only control is scrubbed
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_main_ctrl  <= '0;
    end else if (w_main_free && r_skid_valid) begin
      r_out_valid  <= 1'b1;
      r_main_ctrl  <= r_skid_ctrl;
      r_main_data  <= r_skid_data;
      r_skid_valid <= w_accept;
      r_in_ready   <= ~w_accept;
      if (w_accept) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end else if (w_main_free) begin
      r_out_valid <= w_accept;
      r_in_ready  <= 1'b1;
      if (w_accept) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
      r_skid_ctrl  <= in_ctrl;
      r_skid_data  <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || bubble_clr) begin
      r_bubble_cnt <= '0;
    end else if (!r_out_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  generate
    if (GATE_CTRL != 0) begin : g_gate_ctrl
      assign out_ctrl = r_out_valid ? r_main_ctrl : '0;
    end else begin : g_raw_ctrl
      assign out_ctrl = r_main_ctrl;
    end
  endgenerate

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_main_data;
  assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage_reg
// Brief    : Vector-table bench for id_ex_stage_reg (gated and ungated copies)
// Revision : 1.0
// ============================================================================
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, flush, bubble_clr;
  logic [9:0]  in_ctrl;
  logic [25:0] in_data;

  logic        in_ready, out_valid, ng_in_ready, ng_out_valid;
  logic [9:0]  out_ctrl, ng_out_ctrl;
  logic [25:0] out_data, ng_out_data;
  logic [15:0] bubble_cnt;
  logic [3:0]  ng_bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .flush(flush), .bubble_cnt(bubble_cnt), .bubble_clr(bubble_clr)
  );

  id_ex_stage_reg #(.GATE_CTRL(0), .CNT_W(4)) dut_ng (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ng_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ng_out_valid),
    .out_ready(out_ready), .out_ctrl(ng_out_ctrl), .out_data(ng_out_data),
    .flush(flush), .bubble_cnt(ng_bubble_cnt), .bubble_clr(bubble_clr)
  );

  typedef struct {
    logic        rst, iv, ordy, fl, clr;
    logic [9:0]  ic;
    logic [25:0] id;
    logic        ov, ir;
    logic [9:0]  oc;
    logic [25:0] od;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic iv, input logic ordy, input logic fl,
                       input logic clr, input logic [9:0] ic, input logic [25:0] id);
    rst = r; in_valid = iv; out_ready = ordy; flush = fl; bubble_clr = clr;
    in_ctrl = ic; in_data = id;
  endtask

  // Upstream honours the hold rule, so an accept into a full skid must never occur
  always @(posedge clk) begin
    if (rst && in_valid && in_ready && dut.r_skid_valid) begin
      n_fail++;
      $display("FAIL accept_into_full_skid: got 1 expected 0");
    end
  end

  initial begin
    //          rst iv  or  fl  clr ic      id      ov  ir  oc      od      cnt
    vt[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,10'h000,26'h0,1'b0,1'b1,10'h000,26'h0,16'd0};
    vt[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,10'h000,26'h0,1'b0,1'b1,10'h000,26'h0,16'd0};
    vt[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,10'h011,26'h1,1'b1,1'b1,10'h011,26'h1,16'd1};
    vt[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,10'h012,26'h2,1'b1,1'b1,10'h012,26'h2,16'd1};
    vt[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,10'h013,26'h3,1'b1,1'b1,10'h013,26'h3,16'd1};
    vt[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,10'h014,26'h4,1'b1,1'b1,10'h014,26'h4,16'd1};
    vt[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,10'h000,26'h0,1'b0,1'b1,10'h000,26'h4,16'd1};
    vt[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,10'h000,26'h0,1'b0,1'b1,10'h000,26'h4,16'd2};
    vt[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,10'h0AA,26'hA,1'b1,1'b1,10'h0AA,26'hA,16'd3};
    vt[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,10'h0BB,26'hB,1'b1,1'b0,10'h0AA,26'hA,16'd3};
    vt[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0,10'h0CC,26'hC,1'b1,1'b0,10'h0AA,26'hA,16'd3};
    vt[11] = '{1'b1,1'b1,1'b1,1'b0,1'b0,10'h0CC,26'hC,1'b1,1'b1,10'h0BB,26'hB,16'd3};
    vt[12] = '{1'b1,1'b1,1'b1,1'b0,1'b0,10'h0CC,26'hC,1'b1,1'b1,10'h0CC,26'hC,16'd3};
    vt[13] = '{1'b1,1'b0,1'b1,1'b0,1'b0,10'h000,26'h0,1'b0,1'b1,10'h000,26'hC,16'd3};
    vt[14] = '{1'b1,1'b1,1'b0,1'b0,1'b0,10'h3FF,26'h5,1'b1,1'b1,10'h3FF,26'h5,16'd4};
    vt[15] = '{1'b1,1'b1,1'b0,1'b0,1'b0,10'h066,26'h6,1'b1,1'b0,10'h3FF,26'h5,16'd4};
    vt[16] = '{1'b1,1'b1,1'b0,1'b1,1'b0,10'h077,26'h7,1'b0,1'b1,10'h000,26'h5,16'd4};
    vt[17] = '{1'b1,1'b0,1'b1,1'b0,1'b0,10'h000,26'h0,1'b0,1'b1,10'h000,26'h5,16'd5};
    vt[18] = '{1'b1,1'b0,1'b1,1'b0,1'b0,10'h000,26'h0,1'b0,1'b1,10'h000,26'h5,16'd6};
    vt[19] = '{1'b1,1'b0,1'b1,1'b0,1'b1,10'h000,26'h0,1'b0,1'b1,10'h000,26'h5,16'd0};
    vt[20] = '{1'b1,1'b0,1'b1,1'b0,1'b0,10'h000,26'h0,1'b0,1'b1,10'h000,26'h5,16'd1};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 26'h0);

    for (int i = 0; i < 21; i++) begin
      drive(vt[i].rst, vt[i].iv, vt[i].ordy, vt[i].fl, vt[i].clr, vt[i].ic, vt[i].id);
      step();
      chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vt[i].ov});
      chk($sformatf("v%0d_in_ready", i),  {31'b0, in_ready},  {31'b0, vt[i].ir});
      chk($sformatf("v%0d_out_ctrl", i),  {22'b0, out_ctrl},  {22'b0, vt[i].oc});
      chk($sformatf("v%0d_out_data", i),  {6'b0, out_data},   {6'b0, vt[i].od});
      chk($sformatf("v%0d_bubble_cnt", i), {16'b0, bubble_cnt}, {16'b0, vt[i].cnt});
    end

    // Gating: held control 0x2AA once the beat has drained
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h2AA, 26'h2A);
    step();
    chk("gate_loaded_ctrl", {22'b0, out_ctrl}, 32'h2AA);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0, 26'h0);
    step();
    chk("gate_out_valid", {31'b0, out_valid}, 32'h0);
    chk("gate_on_ctrl", {22'b0, out_ctrl}, 32'h0);
    chk("gate_off_ctrl", {22'b0, ng_out_ctrl}, 32'h2AA);

    // Fill main and skid, then assert reset and flush together
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h111, 26'h11);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h122, 26'h12);
    step();
    chk("rf_skid_full_in_ready", {31'b0, in_ready}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h133, 26'h13);
    step();
    chk("rf_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rf_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rf_out_ctrl", {22'b0, out_ctrl}, 32'h0);
    chk("rf_out_data", {6'b0, out_data}, 32'h0);
    chk("rf_bubble_cnt", {16'b0, bubble_cnt}, 32'h0);
    chk("rf_ng_out_ctrl", {22'b0, ng_out_ctrl}, 32'h0);
    chk("rf_ng_bubble_cnt", {28'b0, ng_bubble_cnt}, 32'h0);

    // 4-bit counter saturation on the ungated copy
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 26'h0);
    for (int i = 0; i < 14; i++) step();
    chk("sat_cnt_14", {28'b0, ng_bubble_cnt}, 32'hE);
    step();
    chk("sat_cnt_15", {28'b0, ng_bubble_cnt}, 32'hF);
    for (int i = 0; i < 5; i++) step();
    chk("sat_cnt_hold", {28'b0, ng_bubble_cnt}, 32'hF);
    chk("wide_cnt_20", {16'b0, bubble_cnt}, 32'd20);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h0, 26'h0);
    step();
    chk("sat_clr", {28'b0, ng_bubble_cnt}, 32'h0);
    chk("wide_clr", {16'b0, bubble_cnt}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 26'h0);
    step();
    chk("sat_after_clr", {28'b0, ng_bubble_cnt}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
